// File: rtl/sram_march_bist.sv
// Purpose : March C- self-test initiator for one single-port SRAM macro (w/ byte mask, registered dout).
// Latency : first op the cycle after an accepted start; 10*2^ADDR_WIDTH op cycles + 1 drain cycle, done after that.
// Backpressure: none; the macro port is owned while busy, and start is ignored in RUN and DRAIN.
// Ports   : clk/rstb (sync active-low); start -> busy/done/fail/err_count/fail_addr/fail_elem/fail_data;
//           sram_we/sram_wmask/sram_addr/sram_din drive the macro, sram_dout returns read data one cycle later.
module sram_march_bist #(
   parameter int                    ADDR_WIDTH    = 9,
   parameter int                    DATA_WIDTH    = 64,
   parameter int                    WMASK_WIDTH   = 8,
   parameter logic [DATA_WIDTH-1:0] BACKGROUND    = '0,
   parameter int                    ERR_CNT_WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     rstb,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     fail,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic [ADDR_WIDTH-1:0]    fail_addr,
   output logic [2:0]               fail_elem,
   output logic [DATA_WIDTH-1:0]    fail_data,
   output logic                     sram_we,
   output logic [WMASK_WIDTH-1:0]   sram_wmask,
   output logic [ADDR_WIDTH-1:0]    sram_addr,
   output logic [DATA_WIDTH-1:0]    sram_din,
   input  logic [DATA_WIDTH-1:0]    sram_dout
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0]    ADDR_MAX = '1;
   localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = 1;
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE  = 1;

   state_t                   state_q, state_d;
   logic [2:0]               elem_q, elem_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic                     phase_q, phase_d;     // 0: first op at this address, 1: second op
   logic                     cmp_vld_q, cmp_vld_d;
   logic [DATA_WIDTH-1:0]    cmp_exp_q, cmp_exp_d;
   logic [ADDR_WIDTH-1:0]    cmp_addr_q, cmp_addr_d;
   logic [2:0]               cmp_elem_q, cmp_elem_d;
   logic                     fail_q, fail_d;
   logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
   logic [ADDR_WIDTH-1:0]    faddr_q, faddr_d;
   logic [2:0]               felem_q, felem_d;
   logic [DATA_WIDTH-1:0]    fdata_q, fdata_d;

   logic                  single_op, is_read, descending, last_addr, mismatch;
   logic [DATA_WIDTH-1:0] rd_exp, wr_dat;

   // E0 (w0) and E5 (r0) have one op per address; E1..E4 are (read, write) pairs.
   assign single_op  = (elem_q == 3'd0) || (elem_q == 3'd5);
   assign is_read    = (elem_q != 3'd0) && !phase_q;
   assign descending = (elem_q == 3'd3) || (elem_q == 3'd4);
   assign rd_exp     = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~BACKGROUND : BACKGROUND;
   assign wr_dat     = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~BACKGROUND : BACKGROUND;
   assign last_addr  = descending ? (addr_q == '0) : (addr_q == ADDR_MAX);
   assign mismatch   = cmp_vld_q && (sram_dout != cmp_exp_q);

   always_comb begin
      state_d    = state_q;
      elem_d     = elem_q;
      addr_d     = addr_q;
      phase_d    = phase_q;
      cmp_vld_d  = 1'b0;
      cmp_exp_d  = cmp_exp_q;
      cmp_addr_d = cmp_addr_q;
      cmp_elem_d = cmp_elem_q;
      fail_d     = fail_q;
      err_d      = err_q;
      faddr_d    = faddr_q;
      felem_d    = felem_q;
      fdata_d    = fdata_q;
      sram_we    = 1'b0;
      sram_wmask = '0;
      sram_addr  = '0;
      sram_din   = '0;

      // Compare stage for the read issued last cycle; only the first failure is latched.
      if (mismatch) begin
         fail_d = 1'b1;
         if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
         if (!fail_q) begin
            faddr_d = cmp_addr_q;
            felem_d = cmp_elem_q;
            fdata_d = sram_dout;
         end
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               elem_d  = 3'd0;
               addr_d  = '0;
               phase_d = 1'b0;
               fail_d  = 1'b0;
               err_d   = '0;
               faddr_d = '0;
               felem_d = '0;
               fdata_d = '0;
            end
         end
         ST_RUN: begin
            sram_we    = !is_read;
            sram_wmask = is_read ? '0 : '1;
            sram_addr  = addr_q;
            sram_din   = is_read ? '0 : wr_dat;
            if (is_read) begin
               cmp_vld_d  = 1'b1;
               cmp_exp_d  = rd_exp;
               cmp_addr_d = addr_q;
               cmp_elem_d = elem_q;
            end
            if (single_op || phase_q) begin
               phase_d = 1'b0;
               if (last_addr) begin
                  if (elem_q == 3'd5) begin
                     state_d = ST_DRAIN;
                  end else begin
                     elem_d = elem_q + 3'd1;
                     // E3 and E4 walk downward, so they start at the top address.
                     addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
                  end
               end else begin
                  addr_d = descending ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
               end
            end else begin
               phase_d = 1'b1;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q    <= ST_IDLE;
         elem_q     <= '0;
         addr_q     <= '0;
         phase_q    <= 1'b0;
         cmp_vld_q  <= 1'b0;
         cmp_exp_q  <= '0;
         cmp_addr_q <= '0;
         cmp_elem_q <= '0;
         fail_q     <= 1'b0;
         err_q      <= '0;
         faddr_q    <= '0;
         felem_q    <= '0;
         fdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         elem_q     <= elem_d;
         addr_q     <= addr_d;
         phase_q    <= phase_d;
         cmp_vld_q  <= cmp_vld_d;
         cmp_exp_q  <= cmp_exp_d;
         cmp_addr_q <= cmp_addr_d;
         cmp_elem_q <= cmp_elem_d;
         fail_q     <= fail_d;
         err_q      <= err_d;
         faddr_q    <= faddr_d;
         felem_q    <= felem_d;
         fdata_q    <= fdata_d;
      end
   end

   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign fail      = fail_q;
   assign err_count = err_q;
   assign fail_addr = faddr_q;
   assign fail_elem = felem_q;
   assign fail_data = fdata_q;

endmodule

// File: tb/tb_sram_march_bist.sv
module tb_sram_march_bist;
   localparam int          D   = 512;
   localparam logic [63:0] BG1 = 64'hA5A5_A5A5_A5A5_A5A5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstb, start, sel, mem_clr;
   logic [63:0] sram_dout;

   logic        d0_busy, d0_done, d0_fail, d0_we, d1_busy, d1_done, d1_fail, d1_we;
   logic [11:0] d0_err, d1_err;
   logic [8:0]  d0_faddr, d0_addr, d1_faddr, d1_addr;
   logic [2:0]  d0_felem, d1_felem;
   logic [63:0] d0_fdata, d0_din, d1_fdata, d1_din;
   logic [7:0]  d0_wmask, d1_wmask;

   sram_march_bist u_dut0 (
      .clk(clk), .rstb(rstb), .start(start & ~sel),
      .busy(d0_busy), .done(d0_done), .fail(d0_fail), .err_count(d0_err),
      .fail_addr(d0_faddr), .fail_elem(d0_felem), .fail_data(d0_fdata),
      .sram_we(d0_we), .sram_wmask(d0_wmask), .sram_addr(d0_addr), .sram_din(d0_din),
      .sram_dout(sram_dout));

   sram_march_bist #(.BACKGROUND(BG1)) u_dut1 (
      .clk(clk), .rstb(rstb), .start(start & sel),
      .busy(d1_busy), .done(d1_done), .fail(d1_fail), .err_count(d1_err),
      .fail_addr(d1_faddr), .fail_elem(d1_felem), .fail_data(d1_fdata),
      .sram_we(d1_we), .sram_wmask(d1_wmask), .sram_addr(d1_addr), .sram_din(d1_din),
      .sram_dout(sram_dout));

   // The idle instance drives all-zero port signals, so one shared macro model suffices.
   logic        m_busy, m_done, m_fail, m_we;
   logic [11:0] m_err;
   logic [8:0]  m_faddr, m_addr;
   logic [2:0]  m_felem;
   logic [63:0] m_fdata, m_din;
   logic [7:0]  m_wmask;
   assign m_busy  = sel ? d1_busy  : d0_busy;
   assign m_done  = sel ? d1_done  : d0_done;
   assign m_fail  = sel ? d1_fail  : d0_fail;
   assign m_err   = sel ? d1_err   : d0_err;
   assign m_faddr = sel ? d1_faddr : d0_faddr;
   assign m_felem = sel ? d1_felem : d0_felem;
   assign m_fdata = sel ? d1_fdata : d0_fdata;
   assign m_we    = sel ? d1_we    : d0_we;
   assign m_wmask = sel ? d1_wmask : d0_wmask;
   assign m_addr  = sel ? d1_addr  : d0_addr;
   assign m_din   = sel ? d1_din   : d0_din;

   // Fault injection knobs
   logic       sa_en, sa_val, cf_en;
   logic [8:0] sa_addr, cf_aggr, cf_vic;
   int         sa_bit, cf_bit;

   function automatic logic [63:0] apply_sa(input logic [8:0] a, input logic [63:0] v);
      logic [63:0] r;
      r = v;
      if (sa_en && a == sa_addr) r[sa_bit] = sa_val;
      return r;
   endfunction

   function automatic logic [63:0] expand(input logic [7:0] m);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = m[i/8];
      return r;
   endfunction

   // Single-port SRAM with registered read data
   logic [63:0] mem [D];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < D; i++) mem[i] <= '0;
      end else if (m_we) begin
         mem[m_addr] <= apply_sa(m_addr, (mem[m_addr] & ~expand(m_wmask)) | (m_din & expand(m_wmask)));
         if (cf_en && m_addr == cf_aggr) mem[cf_vic] <= mem[cf_vic] ^ (64'd1 << cf_bit);
      end else begin
         sram_dout <= mem[m_addr];
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Reference: the March C- element table walked over an array, with the same faults applied.
   typedef struct packed {
      logic        we;
      logic [7:0]  wm;
      logic [8:0]  ad;
      logic [63:0] dn;
   } op_t;
   op_t         exp_q[$];
   int          exp_err;
   logic        exp_fail;
   logic [8:0]  exp_faddr;
   logic [2:0]  exp_felem;
   logic [63:0] exp_fdata;

   task automatic build_model(input logic [63:0] bg);
      logic [63:0] m [D];
      int rd_k[6];
      int wr_k[6];
      rd_k = '{-1, 0, 1, 0, 1, 0};   // -1: no read, 0: r0, 1: r1
      wr_k = '{ 0, 1, 0, 1, 0, -1};  // -1: no write, 0: w0, 1: w1
      exp_q.delete();
      exp_err = 0; exp_fail = 1'b0; exp_faddr = '0; exp_felem = '0; exp_fdata = '0;
      for (int a = 0; a < D; a++) m[a] = '0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < D; i++) begin
            int a;
            op_t o;
            logic [63:0] v;
            a = (e == 3 || e == 4) ? D - 1 - i : i;
            if (rd_k[e] >= 0) begin
               v = (rd_k[e] == 1) ? ~bg : bg;
               o.we = 1'b0; o.wm = 8'h00; o.ad = 9'(a); o.dn = '0;
               exp_q.push_back(o);
               if (m[a] != v) begin
                  if (!exp_fail) begin
                     exp_faddr = 9'(a); exp_felem = 3'(e); exp_fdata = m[a];
                  end
                  exp_fail = 1'b1;
                  if (exp_err < 4095) exp_err++;
               end
            end
            if (wr_k[e] >= 0) begin
               v = (wr_k[e] == 1) ? ~bg : bg;
               o.we = 1'b1; o.wm = 8'hFF; o.ad = 9'(a); o.dn = v;
               exp_q.push_back(o);
               m[a] = apply_sa(9'(a), v);
               if (cf_en && 9'(a) == cf_aggr) m[cf_vic] = m[cf_vic] ^ (64'd1 << cf_bit);
            end
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_flags"}, 64'({m_busy, m_done, m_fail, m_err, m_faddr, m_felem}), 64'd0);
      chk({tag, "_fdata"}, m_fdata, 64'd0);
      chk({tag, "_port"},  64'({m_we, m_wmask, m_addr}), 64'd0);
      chk({tag, "_din"},   m_din, 64'd0);
   endtask

   task automatic do_run(input string tag, input logic [63:0] bg, input int ign_cyc,
                         input bit drain_pulse, input int rst_cyc);
      int busy_n, done_cyc, trace_bad, wr_n, rd_n;
      busy_n = 0; done_cyc = -1; trace_bad = 0; wr_n = 0; rd_n = 0;
      build_model(bg);
      @(negedge clk); mem_clr = 1'b1;
      @(negedge clk); mem_clr = 1'b0; start = 1'b1;
      for (int cyc = 0; cyc < 6000 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc == 0) chk({tag, "_clr"}, 64'({m_done, m_fail, m_err}), 64'd0);
         if (cyc == rst_cyc) begin
            rstb = 1'b0;
            @(negedge clk);
            check_zero({tag, "_rst"});
            rstb = 1'b1;
            return;
         end
         if (cyc == ign_cyc || (drain_pulse && cyc == 5120)) start = 1'b1;
         if (m_busy) busy_n++;
         if (m_done) done_cyc = cyc;
         if (cyc < 10 * D) begin
            if ({m_we, m_wmask, m_addr, m_din} !== exp_q[cyc]) trace_bad++;
            if (m_we) wr_n++; else rd_n++;
         end
      end
      start = 1'b0;
      chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd5121);
      chk({tag, "_done_cycle"}, 64'(done_cyc), 64'd5121);
      chk({tag, "_busy_end"}, 64'(m_busy), 64'd0);
      chk({tag, "_trace"}, 64'(trace_bad), 64'd0);
      chk({tag, "_writes"}, 64'(wr_n), 64'(5 * D));
      chk({tag, "_reads"}, 64'(rd_n), 64'(5 * D));
      chk({tag, "_fail"}, 64'(m_fail), 64'(exp_fail));
      chk({tag, "_err"}, 64'(m_err), 64'(exp_err));
      if (exp_fail) begin
         chk({tag, "_faddr"}, 64'(m_faddr), 64'(exp_faddr));
         chk({tag, "_felem"}, 64'(m_felem), 64'(exp_felem));
         chk({tag, "_fdata"}, m_fdata, exp_fdata);
      end
   endtask

   initial begin
      sel = 1'b0; rstb = 1'b0; start = 1'b0; mem_clr = 1'b0;
      sa_en = 1'b0; sa_val = 1'b0; sa_addr = '0; sa_bit = 0;
      cf_en = 1'b0; cf_aggr = '0; cf_vic = '0; cf_bit = 0;
      repeat (3) @(negedge clk);
      check_zero("por");
      rstb = 1'b1;

      // Fault-free, with start pulses in RUN and DRAIN that must be ignored
      do_run("clean", 64'h0, int'($urandom_range(0, 5119)), 1'b1, -1);

      // Bit 5 of 0x1A3 stuck at 0
      sa_en = 1'b1; sa_addr = 9'h1A3; sa_bit = 5; sa_val = 1'b0;
      do_run("sa1a3", 64'h0, -1, 1'b0, -1);
      chk("sa1a3_const_addr", 64'(m_faddr), 64'h1A3);
      chk("sa1a3_const_elem", 64'(m_felem), 64'd2);
      chk("sa1a3_const_data", m_fdata, 64'hFFFF_FFFF_FFFF_FFDF);
      chk("sa1a3_const_err", 64'(m_err), 64'd2);

      // Restart from DONE after a failing run
      sa_en = 1'b0;
      do_run("rerun", 64'h0, -1, 1'b0, -1);

      // Random stuck-at fault
      sa_en = 1'b1; sa_addr = 9'($urandom_range(0, D - 1));
      sa_bit = int'($urandom_range(0, 63)); sa_val = 1'($urandom_range(0, 1));
      do_run("sa_rand", 64'h0, int'($urandom_range(0, 5119)), 1'b0, -1);

      // Reset mid-run, then a fresh clean run
      sa_addr = 9'h005; sa_bit = 0; sa_val = 1'b0;
      do_run("abort", 64'h0, -1, 1'b0, 3000);
      sa_en = 1'b0;
      do_run("post_rst", 64'h0, -1, 1'b0, -1);

      // Coupling fault with the A5 background: writing 0x010 flips bit 0 of 0x011
      sel = 1'b1;
      cf_en = 1'b1; cf_aggr = 9'h010; cf_vic = 9'h011; cf_bit = 0;
      do_run("cf_a5", BG1, -1, 1'b0, -1);
      chk("cf_a5_const_fail", 64'(m_fail), 64'd1);
      chk("cf_a5_const_addr", 64'(m_faddr), 64'h011);
      sel = 1'b0;

      // Random coupling fault
      cf_aggr = 9'($urandom_range(0, D - 1));
      cf_vic  = cf_aggr + 9'($urandom_range(1, D - 1));
      cf_bit  = int'($urandom_range(0, 63));
      do_run("cf_rand", 64'h0, -1, 1'b0, -1);
      cf_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
